control_unit: RTL and testbench

//  Multicycle FSM sequencing the 18-bit CPU datapath: instruction fetch, decode, execute,

---
 rtl/cpu_defs_pkg.sv | 39 +++
 rtl/control_unit.sv | 146 ++++++++++++++
 tb/tb_control_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the 18-bit CPU: opcode values, FSM state encodings
// and small decode helpers used by the control unit and its bench.
package cpu_defs_pkg;

    localparam logic [3:0] OP_LD   = 4'b1000;
    localparam logic [3:0] OP_ST   = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1010;
    localparam logic [3:0] OP_JE   = 4'b1011;
    localparam logic [3:0] OP_JA   = 4'b1100;
    localparam logic [3:0] OP_JB   = 4'b1101;
    localparam logic [3:0] OP_NOP  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    function automatic logic is_alu(input logic [3:0] op);
        return ~op[3];
    endfunction

    // Conditions are evaluated on the architectural (latched) flags.
    function automatic logic jump_taken(input logic [3:0] op, input logic zf, input logic cf);
        case (op)
            OP_JMP:  return 1'b1;
            OP_JE:   return zf;
            OP_JA:   return ~zf & ~cf;
            OP_JB:   return cf;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_unit.sv
// Multicycle control FSM for the 18-bit CPU datapath: sequences fetch, decode,
// execute, memory and write-back, holds ZF/CF and counts retired instructions.
module control_unit
    import cpu_defs_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ir_opcode,
    input  logic             alu_zf,
    input  logic             alu_cf,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             rf_write,
    output logic             rf_src_sel,
    output logic [0:0]       alu_b_sel,
    output logic [1:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             flag_zf,
    output logic             flag_cf,
    output logic             busy,
    output logic             halted,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       opc_q;
    logic             retire;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            opc_q   <= 4'd0;
            flag_zf <= 1'b0;
            flag_cf <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                opc_q <= ir_opcode;
            if (state_q == S_EXEC && is_alu(opc_q)) begin
                flag_zf <= alu_zf;
                flag_cf <= alu_cf;
            end
            if (retire && cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // Decode uses ir_opcode directly since opc_q only captures it at the end of DECODE.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (ir_opcode == OP_HALT) begin
                    state_d = S_HALT;
                    retire  = 1'b1;
                end else if (ir_opcode == OP_NOP) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_alu(opc_q)) begin
                    state_d = S_WB;
                end else if (opc_q == OP_LD || opc_q == OP_ST) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_MEM: begin
                if (opc_q == OP_LD) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        rf_write   = 1'b0;
        rf_src_sel = 1'b0;
        alu_b_sel  = 1'b0;
        alu_op     = 2'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
            end
            S_EXEC: begin
                if (is_alu(opc_q)) begin
                    alu_op    = opc_q[1:0];
                    alu_b_sel = opc_q[2];
                end else begin
                    pc_load = jump_taken(opc_q, flag_zf, flag_cf);
                end
            end
            S_MEM: begin
                mem_read  = (opc_q == OP_LD);
                mem_write = (opc_q == OP_ST);
            end
            S_WB: begin
                rf_write   = 1'b1;
                rf_src_sel = (opc_q == OP_LD);
                if (is_alu(opc_q)) begin
                    alu_op    = opc_q[1:0];
                    alu_b_sel = opc_q[2];
                end
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted      = (state_q == S_HALT);
    assign state_o     = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks ALU, LD/ST, jumps, HALT, reset and
// counter saturation, comparing outputs against hand-computed values.
module tb_control_unit;
    import cpu_defs_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, start, alu_zf, alu_cf;
    logic [3:0]    ir_opcode;
    logic          ir_load, pc_inc, pc_load, rf_write, rf_src_sel, mem_read, mem_write;
    logic [0:0]    alu_b_sel;
    logic [1:0]    alu_op;
    logic          flag_zf, flag_cf, busy, halted;
    logic [2:0]    state_o;
    logic [CW-1:0] instr_count;
    logic [6:0]    strobes;

    int checkCount = 0;
    int errorCount = 0;

    control_unit #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .ir_opcode(ir_opcode),
        .alu_zf(alu_zf), .alu_cf(alu_cf), .ir_load(ir_load), .pc_inc(pc_inc),
        .pc_load(pc_load), .rf_write(rf_write), .rf_src_sel(rf_src_sel),
        .alu_b_sel(alu_b_sel), .alu_op(alu_op), .mem_read(mem_read),
        .mem_write(mem_write), .flag_zf(flag_zf), .flag_cf(flag_cf), .busy(busy),
        .halted(halted), .state_o(state_o), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Strobe order: ir_load pc_inc pc_load rf_write rf_src_sel mem_read mem_write
    assign strobes = {ir_load, pc_inc, pc_load, rf_write, rf_src_sel, mem_read, mem_write};

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic [3:0] op,
                                 input logic zf, input logic cf);
        rst       = r;
        start     = s;
        ir_opcode = op;
        alu_zf    = zf;
        alu_cf    = cf;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyStimulus(1, 0, 4'd0, 0, 0);
        tick();
        tick();
        checkOutput("rst_state", state_o, S_IDLE);
        checkOutput("rst_strobes", strobes, 7'b0);
        checkOutput("rst_count", instr_count, 0);
        checkOutput("rst_busy", busy, 0);

        // ALU immediate op=2 with ZF set
        applyStimulus(0, 1, 4'b0110, 1, 0);
        tick();
        checkOutput("alu_fetch_strobes", strobes, 7'b1100000);
        checkOutput("alu_fetch_busy", busy, 1);
        start = 0;
        tick();
        checkOutput("alu_decode_state", state_o, S_DECODE);
        tick();
        checkOutput("alu_exec_state", state_o, S_EXEC);
        checkOutput("alu_exec_op", alu_op, 2);
        checkOutput("alu_exec_bsel", alu_b_sel, 1);
        checkOutput("alu_exec_strobes", strobes, 7'b0);
        tick();
        checkOutput("alu_wb_strobes", strobes, 7'b0001000);
        checkOutput("alu_wb_op", alu_op, 2);
        checkOutput("alu_wb_zf", flag_zf, 1);
        checkOutput("alu_wb_cf", flag_cf, 0);
        ir_opcode = OP_LD;
        tick();
        checkOutput("alu_retired_count", instr_count, 1);
        checkOutput("alu_next_op_zero", alu_op, 0);

        // LD then ST
        tick();
        tick();
        checkOutput("ld_exec_strobes", strobes, 7'b0);
        tick();
        checkOutput("ld_mem_strobes", strobes, 7'b0000010);
        tick();
        checkOutput("ld_wb_strobes", strobes, 7'b0001100);
        ir_opcode = OP_ST;
        tick();
        checkOutput("ld_count", instr_count, 2);
        tick();
        tick();
        tick();
        checkOutput("st_mem_strobes", strobes, 7'b0000001);
        tick();
        checkOutput("st_next_state", state_o, S_FETCH);
        checkOutput("st_count", instr_count, 3);

        // ALU zf=1 then JE taken
        ir_opcode = 4'b0000;
        tick();
        tick();
        tick();
        checkOutput("alu2_zf", flag_zf, 1);
        ir_opcode = OP_JE;
        alu_zf = 0;
        tick();
        tick();
        tick();
        checkOutput("je_taken", pc_load, 1);
        ir_opcode = 4'b0001;
        tick();
        checkOutput("je_count", instr_count, 5);
        // ALU zf=0 then JE not taken
        tick();
        tick();
        checkOutput("alu3_op", alu_op, 1);
        checkOutput("alu3_bsel", alu_b_sel, 0);
        tick();
        checkOutput("alu3_zf", flag_zf, 0);
        ir_opcode = OP_JE;
        tick();
        tick();
        tick();
        checkOutput("je_not_taken", pc_load, 0);
        ir_opcode = OP_JA;
        tick();
        tick();
        tick();
        checkOutput("ja_taken", pc_load, 1);
        ir_opcode = OP_JB;
        alu_zf = 1;
        alu_cf = 1;
        tick();
        tick();
        tick();
        checkOutput("jb_not_taken", pc_load, 0);
        ir_opcode = OP_HALT;
        tick();
        checkOutput("jump_flags_kept", {flag_zf, flag_cf}, 2'b00);
        checkOutput("jb_count", instr_count, 9);

        // HALT
        tick();
        tick();
        checkOutput("halt_halted", halted, 1);
        checkOutput("halt_busy", busy, 0);
        checkOutput("halt_count", instr_count, 10);
        start = 1;
        tick();
        tick();
        checkOutput("halt_ignores_start", state_o, S_HALT);
        applyStimulus(1, 0, 4'd0, 0, 0);
        tick();
        checkOutput("halt_rst_state", state_o, S_IDLE);
        checkOutput("halt_rst_halted", halted, 0);
        checkOutput("halt_rst_count", instr_count, 0);

        // Reset in EXEC of an ALU op
        applyStimulus(0, 1, 4'b0111, 1, 1);
        tick();
        start = 0;
        tick();
        tick();
        checkOutput("abort_exec_state", state_o, S_EXEC);
        rst = 1;
        tick();
        checkOutput("abort_state", state_o, S_IDLE);
        checkOutput("abort_flags", {flag_zf, flag_cf}, 2'b00);
        checkOutput("abort_strobes", strobes, 7'b0);
        rst = 0;
        tick();
        checkOutput("abort_no_wb", strobes, 7'b0);
        checkOutput("abort_count", instr_count, 0);
        applyStimulus(1, 1, OP_NOP, 0, 0);
        tick();
        checkOutput("rst_beats_start", state_o, S_IDLE);

        // Counter saturation with NOPs
        applyStimulus(0, 1, OP_NOP, 0, 0);
        tick();
        start = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            tick();
            if (i == 14)
                checkOutput("sat_before", instr_count, 14);
        end
        checkOutput("sat_hold", instr_count, 15);
        checkOutput("nop_state", state_o, S_FETCH);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
